// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: decodes the IR opcode and steps the shared
// datapath through fetch/decode/execute/memory/write-back with a memory wait watchdog.
module mc_control_fsm #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       illegal_op_o,
    output logic       bus_error_o,
    output logic [3:0] state_o
);
    localparam logic [3:0] S_START    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_EXEC_R   = 4'd7;
    localparam logic [3:0] S_R_WB     = 4'd8;
    localparam logic [3:0] S_EXEC_I   = 4'd9;
    localparam logic [3:0] S_I_WB     = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_HALT     = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Counter value seen on the last tolerated not-ready cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    logic [3:0] state, next_state;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       bus_error;
    logic       wait_state, timeout;

    assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout    = wait_state && !mem_ready_i && (wait_cnt == WAIT_LAST);

    always_comb begin
        next_state = S_START;
        case (state)
            S_START:  next_state = S_FETCH;
            S_FETCH:  next_state = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE:                 next_state = S_EXEC_R;
                    OP_ADDI, OP_ORI, OP_LUI:  next_state = S_EXEC_I;
                    OP_LW, OP_SW:             next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:           next_state = S_BRANCH;
                    OP_J:                     next_state = S_JUMP;
                    default:                  next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode_i == OP_LW)      next_state = S_MEM_RD;
                else if (opcode_i == OP_SW) next_state = S_MEM_WR;
                else                        next_state = S_FETCH;
            end
            S_MEM_RD: next_state = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB: next_state = S_FETCH;
            S_MEM_WR: next_state = mem_ready_i ? S_FETCH : S_MEM_WR;
            S_EXEC_R: next_state = S_R_WB;
            S_R_WB:   next_state = S_FETCH;
            S_EXEC_I: next_state = S_I_WB;
            S_I_WB:   next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_START;
        endcase
        if (timeout) next_state = S_HALT;
    end

    assign wait_cnt_next = (wait_state && !mem_ready_i && !timeout) ? wait_cnt + 8'd1 : 8'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_START;
            wait_cnt  <= 8'd0;
            bus_error <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
            if (timeout) bus_error <= 1'b1;
        end
    end

    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_dst_o    = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        pc_src_o     = 2'b00;
        illegal_op_o = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                alu_op_o    = 3'b011;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                alu_op_o    = 3'b011;
                case (opcode_i)
                    OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW,
                    OP_BEQ, OP_BNE, OP_J: illegal_op_o = 1'b0;
                    default:              illegal_op_o = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = 3'b011;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b111;
            end
            S_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                case (opcode_i)
                    OP_ADDI: alu_op_o = 3'b100;
                    OP_ORI:  alu_op_o = 3'b001;
                    OP_LUI:  alu_op_o = 3'b010;
                    default: alu_op_o = 3'b000;
                endcase
            end
            S_I_WB: reg_write_o = 1'b1;
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b110;
                pc_src_o    = 2'b01;
                pc_write_o  = ((opcode_i == OP_BEQ) && zero_i) ||
                              ((opcode_i == OP_BNE) && !zero_i);
            end
            S_JUMP: begin
                pc_src_o   = 2'b10;
                pc_write_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus_error_o = bus_error;
    assign state_o     = state;
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle sequencer for the MIPS core. It decodes the opcode held in the instruction register and steps the shared datapath (single memory port, one ALU, PC/IR/ALUOut registers) through fetch, decode, execute, memory and write-back.
- Every memory access uses a ready handshake. A wait-timeout watchdog raises a sticky bus error.
- It sits between the IR opcode field and the datapath mux/enable inputs.

Parameters:
- MEM_WAIT_MAX, 15: consecutive not-ready cycles tolerated in a memory state before the block moves to HALT (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears state, counter and flags.
- opcode_i  in  6  IR[31:26].
- mem_ready_i  in  1  memory completes the access this cycle.
- zero_i  in  1  ALU zero flag.
- pc_write_o  out  1  PC load enable.
- ir_write_o  out  1  IR load enable.
- i_or_d_o  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_to_reg_o  out  1  register write data: 1 = MDR, 0 = ALUOut.
- reg_dst_o  out  1  register write address: 1 = rd, 0 = rt.
- reg_write_o  out  1  register file write enable.
- alu_src_a_o  out  1  ALU A input: 0 = PC, 1 = rs.
- alu_src_b_o  out  2  ALU B input: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- alu_op_o  out  3  111 R-type(funct), 100 ADD-imm, 001 OR, 010 LUI, 011 ADD, 110 SUB, 000 idle.
- pc_src_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op_o  out  1  one-cycle pulse on an unsupported opcode.
- bus_error_o  out  1  sticky memory-timeout flag.
- state_o  out  4  current state, for debug.

Behaviour:
- State encoding:
  - START 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, R_WB 8, EXEC_I 9, I_WB 10, BRANCH 11, JUMP 12, HALT 15.
  - Codes 13 and 14 go to START.
- Reset:
  - State = START, wait counter = 0, bus_error_o = 0.
  - All outputs are 0 during reset and in START.
  - START goes to FETCH unconditionally.
  - Reset asserted mid-access drops the strobes immediately (asynchronous).
- Outputs are combinational from state (plus mem_ready_i/zero_i where noted). Unlisted outputs are 0.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 011.
  - ir_write and pc_write equal mem_ready_i.
  - Stays in FETCH until ready, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 011 (precomputes the branch target).
  - Next state by opcode:
    - 0x00 → EXEC_R
    - 0x08 / 0x0D / 0x0F → EXEC_I
    - 0x23 / 0x2B → MEM_ADDR
    - 0x04 / 0x05 → BRANCH
    - 0x02 → JUMP
    - any other opcode → FETCH, with illegal_op_o = 1 for this cycle.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 011. Next: LW (0x23) → MEM_RD, SW (0x2B) → MEM_WR.
- MEM_RD: mem_read = 1, i_or_d = 1. Waits for ready, then → MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next → FETCH.
- MEM_WR: mem_write = 1, i_or_d = 1. Waits for ready, then → FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 111. Next → R_WB.
- R_WB: reg_write = 1, reg_dst = 1. Next → FETCH.
- EXEC_I:
  - Outputs: alu_src_a = 1, alu_src_b = 10.
  - alu_op by opcode: ADDI 100, ORI 001, LUI 010.
  - Next → I_WB.
- I_WB: reg_write = 1, reg_dst = 0. Next → FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 110, pc_src = 01.
  - pc_write = (opcode 0x04 & zero_i) | (opcode 0x05 & ~zero_i).
  - Next → FETCH.
- JUMP: pc_src = 10, pc_write = 1. Next → FETCH.
- Latency in cycles with zero wait states:
  - Branch and jump: 3.
  - R-type, I-type and SW: 4.
  - LW: 5.
  - Each not-ready cycle adds 1.
- Wait counter:
  - Increments on each FETCH/MEM_RD/MEM_WR cycle with mem_ready_i = 0.
  - Clears whenever ready is seen or the state changes.
  - On the cycle that would be the MEM_WAIT_MAX-th consecutive not-ready cycle, next state = HALT and bus_error_o is set.
  - mem_ready_i = 1 in that same cycle wins: the access completes normally.
- HALT: all outputs 0 except bus_error_o = 1. Only reset exits HALT.
- The opcode is sampled from opcode_i in DECODE, MEM_ADDR, EXEC_I and BRANCH. The IR is stable because ir_write is asserted only in FETCH.

Test Plan:
- Release reset with mem_ready_i = 1 and opcode 0x00 → state sequence 0,1,2,7,8,1. reg_write and reg_dst are 1 only in state 8. All outputs are 0 while reset is low.
- LW (0x23) with mem_ready_i low for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles. MEM_WB has mem_to_reg = 1 and reg_write = 1. Instruction total is 8 cycles.
- BEQ (0x04) with zero_i = 1, then BNE (0x05) with zero_i = 1 → pc_write = 1 with pc_src = 01 in the first BRANCH state, pc_write = 0 in the second.
- ORI (0x0D) → alu_op = 001 and alu_src_b = 10 in EXEC_I. Opcode 0x3F → illegal_op_o pulses exactly 1 cycle in DECODE and the next state is FETCH.
- MEM_WAIT_MAX = 4, SW with mem_ready_i held low → state 15 after 4 cycles in MEM_WR, mem_write then 0, bus_error_o = 1 sticky. Repeat with ready arriving on the 4th cycle → completes normally, bus_error_o = 0.
- Assert reset in the middle of MEM_RD → mem_read_o falls asynchronously. After release: START then FETCH, wait counter 0.
